bus_memory_responder: RTL and testbench
=======================================

BUS_MEMORY_RESPONDER -- requirements
Module: bus_memory_responder

Interface
REQ-001 Parameter DATA_W, default 64, data bus width in bits; fixed at 64 in this generation (8 byte lanes).
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter DEPTH, default 1024, number of DATA_W words stored; power of two, at least 2.
REQ-004 Parameter WAIT_CYCLES, default 2, wait states inserted before the response; range 0..15.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 address  in  ADDR_W  byte address of the request.
REQ-008 memread  in  1  read request; held high until ready.
REQ-009 memwrite  in  1  write request; held high until ready.
REQ-010 size  in  2  access size: 00 byte, 01 half (2 B), 10 word (4 B), 11 dword (8 B).
REQ-011 wdata  in  DATA_W  write data, right-justified.
REQ-012 rdata  out  DATA_W  read data, right-justified, zero-extended.
REQ-013 ready  out  1  one-cycle completion pulse.
REQ-014 err  out  1  error flag; valid only while ready=1.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 IDLE SHALL latch address, size, wdata and the request type when memread or memwrite is high, then go to WAIT, or go directly to RESP when WAIT_CYCLES=0.
REQ-018 WAIT SHALL count WAIT_CYCLES cycles, then go to RESP.
REQ-019 RESP SHALL assert ready for exactly one cycle, then return to IDLE.
REQ-020 ready SHALL rise exactly 1+WAIT_CYCLES cycles after the edge that samples the request.
REQ-021 If memread and memwrite are both low during WAIT, the FSM SHALL abort to IDLE with no write and no ready.
REQ-022 A new request SHALL be accepted no earlier than the cycle after RESP (IDLE), so back-to-back transfers take 2+WAIT_CYCLES cycles.
REQ-023 Word index SHALL be address[3 +: log2(DEPTH)] and lane offset SHALL be address[2:0].
REQ-024 Any nonzero address bit at or above 3+log2(DEPTH) SHALL set err, suppress the write and return rdata=0.
REQ-025 memread and memwrite sampled high together SHALL set err and SHALL perform no access.
REQ-026 A write SHALL update only the 2^size bytes starting at the lane offset, taken from the low bytes of wdata; all other bytes are unchanged.
REQ-027 A read SHALL return the 2^size addressed bytes in rdata[8*2^size-1:0], with the upper bits zero.
REQ-028 rdata SHALL hold its value from RESP until the next RESP.
REQ-029 The memory write SHALL occur on the edge that leaves RESP.

Reset
REQ-030 reset SHALL force IDLE with ready=0, err=0, busy=0, rdata=0 and the wait counter cleared.
REQ-031 reset mid-transfer SHALL cancel the transfer with no write and no ready.
REQ-032 reset SHALL NOT clear memory contents.

Configuration
REQ-033 With MEM_ALIGN_CHECK_EN defined, an offset that is not a multiple of 2^size SHALL set err and suppress the access.
REQ-034 Without MEM_ALIGN_CHECK_EN, offset bits below the size SHALL be forced to zero (silent alignment) and no alignment error is raised.

Structure
REQ-035 Package mem_bus_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD), the FSM state enum and LANES=8.
REQ-036 Sub-module mem_lane_align SHALL perform the combinational byte-enable generation, write-lane shift and read-lane extract.
REQ-037 Storage SHALL be a DEPTH x DATA_W register array inside bus_memory_responder.

Verification
REQ-038 WAIT_CYCLES=2: write dword 0x1122334455667788 at 0x10, then read dword at 0x10 -> ready 3 cycles after each request is sampled, rdata=0x1122334455667788, err=0.
REQ-039 Write byte 0xAB at 0x13 over the previous value, then read dword at 0x10 -> rdata=0x11223344AB667788.
REQ-040 Read half at 0x16 -> rdata=0x0000000000001122; read byte at 0x2000 with DEPTH=1024 -> err=1, rdata=0.
REQ-041 memread and memwrite both high -> ready with err=1 and memory unchanged; drop memread during WAIT -> no ready and busy falls the next cycle.
REQ-042 Word read at 0x12 -> err=1 with MEM_ALIGN_CHECK_EN; without it, the data at 0x10 is returned with err=0.
REQ-043 Assert reset during WAIT of a write -> ready never pulses; a read of the target returns the old value.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the bus memory responder.
//   SZ_*      : access size encodings (byte, half, word, dword)
//   LANES     : byte lanes per data word
//   state_e   : responder FSM states
//   size_lanes: low-justified lane mask for an access size
package mem_bus_pkg;

    localparam int unsigned LANES = 8;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Lanes covered by an access of the given size, starting at lane 0.
    function automatic logic [LANES-1:0] size_lanes(input logic [1:0] size);
        logic [LANES-1:0] lanes;
        case (size)
            SZ_BYTE:  lanes = 8'h01;
            SZ_HALF:  lanes = 8'h03;
            SZ_WORD:  lanes = 8'h0F;
            default:  lanes = 8'hFF;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for one memory word.
//   i_size    : access size encoding
//   i_offset  : lane offset within the word (already aligned by the caller)
//   i_wdata   : right-justified write data
//   i_rword   : full stored word being read
//   o_be_c    : byte enables for the write
//   o_wdata_c : write data shifted onto its lanes
//   o_rdata_c : addressed bytes right-justified, zero-extended
module mem_lane_align
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [1:0]        i_size,
    input  logic [2:0]        i_offset,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rword,
    output logic [LANES-1:0]  o_be_c,
    output logic [DATA_W-1:0] o_wdata_c,
    output logic [DATA_W-1:0] o_rdata_c
);

    logic [LANES-1:0]  w_lanes;
    logic [5:0]        w_shamt;
    logic [DATA_W-1:0] w_bitmask;

    // Shift writes up to the lane offset, shift reads down and trim to size.
    always_comb begin
        w_lanes   = size_lanes(i_size);
        w_shamt   = {i_offset, 3'b000};
        o_be_c    = w_lanes << i_offset;
        o_wdata_c = i_wdata << w_shamt;
        w_bitmask = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_bitmask[8*i +: 8] = {8{w_lanes[i]}};
        end
        o_rdata_c = (i_rword >> w_shamt) & w_bitmask;
    end

endmodule

// File: rtl/bus_memory_responder.sv
// bus_memory_responder: wait-state memory slave with byte/half/word/dword access.
//   i_clock, i_reset     : clock, synchronous active-high reset
//   i_address            : byte address
//   i_memread/i_memwrite : request strobes, held until o_ready
//   i_size               : access size (00 B, 01 H, 10 W, 11 D)
//   i_wdata / o_rdata    : right-justified write / read data
//   o_ready              : one-cycle completion pulse, o_err valid with it
//   o_busy               : high whenever the FSM is not idle
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned accesses raise an error
// instead of being silently aligned down.
module bus_memory_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_memread,
    input  logic              i_memwrite,
    input  logic [1:0]        i_size,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_ready,
    output logic              o_err,
    output logic              o_busy
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned HI_LSB = 3 + IDX_W;
    localparam int unsigned CNT_W  = 4;

    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic [ADDR_W-1:0]  r_addr;
    logic [1:0]         r_size;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_rd, r_wr;

    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [DATA_W-1:0]  r_rdata;
    logic               r_ready, r_err, r_busy;

    logic [ADDR_W-1:0]  w_cur_addr;
    logic [1:0]         w_cur_size;
    logic [DATA_W-1:0]  w_cur_wdata;
    logic               w_cur_rd, w_cur_wr;
    logic [2:0]         w_low_mask, w_offset, w_offset_raw;
    logic               w_misalign, w_oor, w_err;
    logic [IDX_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_rword, w_wdata_sh, w_rd_lane;
    logic [LANES-1:0]   w_be;
    logic               w_mem_we;

    // In IDLE the live request is decoded so a zero-wait access can respond
    // on the sampling edge; afterwards the latched copy is used.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_cur_addr  = i_address;
            w_cur_size  = i_size;
            w_cur_wdata = i_wdata;
            w_cur_rd    = i_memread;
            w_cur_wr    = i_memwrite;
        end else begin
            w_cur_addr  = r_addr;
            w_cur_size  = r_size;
            w_cur_wdata = r_wdata;
            w_cur_rd    = r_rd;
            w_cur_wr    = r_wr;
        end
    end

    assign w_offset_raw = w_cur_addr[2:0];
    assign w_low_mask   = 3'((4'b0001 << w_cur_size) - 4'b0001);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = |(w_offset_raw & w_low_mask);
    assign w_offset   = w_offset_raw;
`else
    assign w_misalign = 1'b0;
    assign w_offset   = w_offset_raw & ~w_low_mask;
`endif

    // Any address bit above the storage range is an error.
    assign w_oor   = (w_cur_addr >> HI_LSB) != '0;
    assign w_idx   = w_cur_addr[3 +: IDX_W];
    assign w_err   = w_oor | (w_cur_rd & w_cur_wr) | w_misalign;
    assign w_rword = r_mem[w_idx];

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .i_size    (w_cur_size),
        .i_offset  (w_offset),
        .i_wdata   (w_cur_wdata),
        .i_rword   (w_rword),
        .o_be_c    (w_be),
        .o_wdata_c (w_wdata_sh),
        .o_rdata_c (w_rd_lane)
    );

    // State and wait counter register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; WAIT aborts when the requester drops both strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_memread || i_memwrite) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!i_memread && !i_memwrite) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request capture.
    always_ff @(posedge i_clock) begin
        if (r_state == ST_IDLE && (i_memread || i_memwrite)) begin
            r_addr  <= i_address;
            r_size  <= i_size;
            r_wdata <= i_wdata;
            r_rd    <= i_memread;
            r_wr    <= i_memwrite;
        end
    end

    // Registered response outputs, loaded on the edge entering RESP.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= (w_state_nxt == ST_RESP);
            r_err   <= (w_state_nxt == ST_RESP) && w_err;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_state_nxt == ST_RESP) begin
                r_rdata <= (w_err || !w_cur_rd) ? '0 : w_rd_lane;
            end
        end
    end

    // Storage update on the edge leaving RESP; reset cancels it but never clears memory.
    assign w_mem_we = !i_reset && (r_state == ST_RESP) && r_wr && !r_rd && !w_err;

    always_ff @(posedge i_clock) begin
        if (w_mem_we) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_ready = r_ready;
    assign o_err   = r_err;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_bus_memory_responder.sv
// tb_bus_memory_responder: directed vector table plus abort and reset sequences.
module tb_bus_memory_responder;

    localparam int WAITC = 2;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        memread;
    logic        memwrite;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bus_memory_responder #(
        .DATA_W      (64),
        .ADDR_W      (32),
        .DEPTH       (1024),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .i_clock    (clk),
        .i_reset    (reset),
        .i_address  (address),
        .i_memread  (memread),
        .i_memwrite (memwrite),
        .i_size     (size),
        .i_wdata    (wdata),
        .o_rdata    (rdata),
        .o_ready    (ready),
        .o_err      (err),
        .o_busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [63:0] wd;
        logic        exp_err;
        logic        chk_rd;
        logic [63:0] exp_rd;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    task automatic check(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for the ready pulse.
    task automatic run_xfer(input logic rd, input logic wr, input logic [31:0] a, input logic [1:0] sz,
                            input logic [63:0] wd, output int lat, output logic e,
                            output logic [63:0] rdv, output logic tmo);
        @(negedge clk);
        memread  = rd;
        memwrite = wr;
        address  = a;
        size     = sz;
        wdata    = wd;
        @(posedge clk);
        lat = 0;
        e   = 1'b0;
        rdv = '0;
        tmo = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ready) begin
                lat = c;
                e   = err;
                rdv = rdata;
                tmo = 1'b0;
                break;
            end
        end
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        e;
        logic [63:0] rdv;
        logic        tmo;
        logic        seen;

        vecs[0]  = '{1'b0, 1'b1, 32'h10,   2'b11, 64'h1122334455667788, 1'b0, 1'b0, 64'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,   2'b11, 64'h0,                1'b0, 1'b1, 64'h1122334455667788};
        vecs[2]  = '{1'b0, 1'b1, 32'h13,   2'b00, 64'hDEADBEEFCAFE00AB, 1'b0, 1'b0, 64'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h10,   2'b11, 64'h0,                1'b0, 1'b1, 64'h11223344AB667788};
        vecs[4]  = '{1'b1, 1'b0, 32'h16,   2'b01, 64'h0,                1'b0, 1'b1, 64'h0000000000001122};
        vecs[5]  = '{1'b1, 1'b0, 32'h2000, 2'b00, 64'h0,                1'b1, 1'b1, 64'h0};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[6]  = '{1'b1, 1'b0, 32'h12,   2'b10, 64'h0,                1'b1, 1'b1, 64'h0};
`else
        vecs[6]  = '{1'b1, 1'b0, 32'h12,   2'b10, 64'h0,                1'b0, 1'b1, 64'h00000000AB667788};
`endif
        vecs[7]  = '{1'b1, 1'b0, 32'h17,   2'b00, 64'h0,                1'b0, 1'b1, 64'h0000000000000011};
        vecs[8]  = '{1'b1, 1'b1, 32'h10,   2'b00, 64'h0,                1'b1, 1'b1, 64'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h4010, 2'b00, 64'h0,                1'b1, 1'b0, 64'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h10,   2'b11, 64'h0,                1'b0, 1'b1, 64'h11223344AB667788};
        vecs[11] = '{1'b0, 1'b1, 32'h20,   2'b11, 64'h0123456789ABCDEF, 1'b0, 1'b0, 64'h0};
        vecs[12] = '{1'b0, 1'b1, 32'h24,   2'b01, 64'h00000000FFFFBEEF, 1'b0, 1'b0, 64'h0};
        vecs[13] = '{1'b1, 1'b0, 32'h20,   2'b11, 64'h0,                1'b0, 1'b1, 64'h0123BEEF89ABCDEF};
        vecs[14] = '{1'b1, 1'b0, 32'h24,   2'b10, 64'h0,                1'b0, 1'b1, 64'h000000000123BEEF};
`ifdef MEM_ALIGN_CHECK_EN
        vecs[15] = '{1'b0, 1'b1, 32'h21,   2'b01, 64'h7777,             1'b1, 1'b0, 64'h0};
        vecs[16] = '{1'b1, 1'b0, 32'h20,   2'b11, 64'h0,                1'b0, 1'b1, 64'h0123BEEF89ABCDEF};
`else
        vecs[15] = '{1'b0, 1'b1, 32'h21,   2'b01, 64'h7777,             1'b0, 1'b0, 64'h0};
        vecs[16] = '{1'b1, 1'b0, 32'h20,   2'b11, 64'h0,                1'b0, 1'b1, 64'h0123BEEF89AB7777};
`endif

        reset    = 1'b1;
        memread  = 1'b0;
        memwrite = 1'b0;
        address  = '0;
        size     = 2'b00;
        wdata    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_ready", 0, 64'(ready), 64'h0);
        check("rst_err",   0, 64'(err),   64'h0);
        check("rst_busy",  0, 64'(busy),  64'h0);
        check("rst_rdata", 0, rdata,      64'h0);

        for (int i = 0; i < NVEC; i++) begin
            run_xfer(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].sz, vecs[i].wd, lat, e, rdv, tmo);
            if (tmo) begin
                checks++;
                errors++;
                $display("FAIL vec_timeout[%0d]: no ready within 20 cycles, expected latency %0d", i, 1 + WAITC);
            end else begin
                check("vec_latency", i, 64'(lat), 64'(1 + WAITC));
                check("vec_err",     i, 64'(e),   64'(vecs[i].exp_err));
                if (vecs[i].chk_rd) check("vec_rdata", i, rdv, vecs[i].exp_rd);
            end
        end

        // Dropping the request during WAIT aborts: busy falls, ready never pulses.
        @(negedge clk);
        memread = 1'b1;
        address = 32'h10;
        size    = 2'b11;
        @(posedge clk);
        @(negedge clk);
        check("abort_busy_wait", 0, 64'(busy), 64'h1);
        memread = 1'b0;
        @(negedge clk);
        check("abort_busy_idle", 0, 64'(busy), 64'h0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | ready;
        end
        check("abort_no_ready", 0, 64'(seen), 64'h0);

        // Reset during WAIT of a write cancels it; memory keeps the old value.
        @(negedge clk);
        memwrite = 1'b1;
        address  = 32'h10;
        size     = 2'b11;
        wdata    = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        check("rstw_busy_wait", 0, 64'(busy), 64'h1);
        reset    = 1'b1;
        memwrite = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rstw_busy",  0, 64'(busy),  64'h0);
        check("rstw_rdata", 0, rdata,      64'h0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | ready;
        end
        check("rstw_no_ready", 0, 64'(seen), 64'h0);
        run_xfer(1'b1, 1'b0, 32'h10, 2'b11, 64'h0, lat, e, rdv, tmo);
        if (tmo) begin
            checks++;
            errors++;
            $display("FAIL rstw_read_timeout[0]: no ready within 20 cycles, expected latency %0d", 1 + WAITC);
        end else begin
            check("rstw_read_err",   0, 64'(e), 64'h0);
            check("rstw_read_rdata", 0, rdv,    64'h11223344AB667788);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
